clmul_arbiter: RTL
==================

# clmul_arbiter

Shares one multi-cycle carry-less multiplier (start/busy/done protocol, 32-bit operands, 64-bit result) between NREQ requesters. Each requester has a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin, sequences the unit's one-cycle start pulse, captures the result on done, and routes it back to the owning requester. It includes a watchdog against a hung unit. It sits between issue ports and the shared `simpleclmul` instance.

## Interface
- NREQ, 2, number of requesters (2..8)
- TIMEOUT, 64, max cycles from start to done before abort (≥ 8)
- clock  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester request accept (one-hot or zero)
- req_mul  in  NREQ  per-requester mode bit, passed to unit
- req_rs1, req_rs2  in  32*NREQ  flattened operands, requester i at [32*i+:32]
- resp_valid  out  NREQ  one-hot response valid
- resp_ready  in  NREQ  per-requester response accept
- resp_rd  out  64  result, shared by all requesters
- resp_err  out  1  response is a watchdog abort (resp_rd = 0)
- clmul_start  out  1  one-cycle start pulse to unit
- clmul_mul  out  1  mode to unit
- clmul_rs1, clmul_rs2  out  32  operands to unit
- clmul_rd  in  64  unit result, valid while clmul_done
- clmul_busy  in  1  unit busy
- clmul_done  in  1  unit result strobe
- err_sticky  out  1  set on any watchdog abort, cleared only by reset

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- IDLE
  - If any req_valid is set and clmul_busy = 0, pick requester g round-robin, searching upward from pointer ptr.
  - Drive req_ready[g] = 1 in the same cycle (combinational). All other req_ready bits are 0.
  - On fire: latch mul, rs1, rs2, and owner = g; set ptr = (g+1) mod NREQ; go to START.
- START
  - clmul_start = 1 for exactly this cycle, with latched operands on clmul_mul/rs1/rs2.
  - Clear the watchdog counter; go to WAIT.
- WAIT
  - Operands stay held.
  - On clmul_done: capture clmul_rd into the result buffer, resp_err = 0, go to RESP.
  - If the counter reaches TIMEOUT first: buffer = 0, resp_err = 1, set err_sticky, go to RESP.
- RESP
  - resp_valid[owner] = 1; resp_rd/resp_err driven from the buffer, stable until accepted.
  - On resp_ready[owner]: go to IDLE. resp_ready bits of other requesters are ignored.
- Unexpected events:
  - clmul_done outside WAIT is ignored.
  - A late done after a timeout abort is discarded.
- Requests never get ready outside IDLE. A requester may drop req_valid before grant without effect.
- Round-robin: a continuously requesting requester waits at most NREQ−1 grants.

## Timing
- Reset values:
  - state IDLE, ptr 0, owner 0
  - req_ready 0, resp_valid 0, resp_rd 0, resp_err 0
  - clmul_start 0, clmul_mul 0, clmul_rs1/rs2 0
  - err_sticky 0, watchdog counter 0
- Cycle timeline:
  - Request fire at cycle 0.
  - clmul_start high in cycle 1.
  - done seen in cycle 1+L, where L is the unit latency.
  - resp_valid high from cycle 2+L.
  - With resp_ready held high, the next grant is possible 1 cycle after the response fires.
- Minimum repeat interval per op: L+3 cycles.
- Watchdog counter counts WAIT cycles. Abort happens on the cycle the count equals TIMEOUT; resp_valid follows the next cycle.
- Reset asserted mid-operation drops the in-flight op; no response is produced. The unit's own reset is the integrator's responsibility.

## Structure
- Package clmul_pkg: state enum (IDLE/START/WAIT/RESP), XLEN = 32, result width 64.
- Sub-module clmul_rr_pick: combinational round-robin picker (req vector + pointer → one-hot grant + index).
- Counter width: $clog2(TIMEOUT+1).

## Test plan
- Single request: requester 0, mul=1, rs1=32'h0000_0003, rs2=32'h0000_0005.
  - Expect clmul_start pulse with those operands, resp_valid = 2'b01.
  - Expect resp_rd equal to the unit's output for those operands (golden model), resp_err = 0.
- Both requesters valid continuously, 4 ops each, reset pointer 0:
  - Grant order 0,1,0,1,…
  - Each response goes to the correct one-hot resp_valid.
- Response backpressure: hold resp_ready low 10 cycles.
  - resp_rd stable and resp_valid held throughout.
  - req_ready = 0 throughout; no second clmul_start.
- Watchdog: stub unit never asserts done, TIMEOUT=8.
  - Expect resp_valid 9 cycles after start, resp_rd = 0, resp_err = 1, err_sticky = 1.
  - A late done is ignored.
- Reset mid-WAIT: drop resetn for 1 cycle.
  - All outputs return to reset values, no response is issued.
  - The next request is granted normally.
- Random traffic: 1000 ops with random valid/ready gaps against the real simpleclmul.
  - Every result matches the golden model.
  - Every requester's results come back in its issue order.

Source files
------------

// File: rtl/clmul_pkg.sv
// Shared types and widths for the carry-less multiplier arbiter.
// Operand width, result width and the sequencing FSM states.
package clmul_pkg;

  localparam int XLEN = 32;
  localparam int RLEN = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/clmul_rr_pick.sv
// Combinational round-robin picker: the first set request at or above ptr_i,
// wrapping around, wins. Produces a one-hot grant and the winner's index.
module clmul_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/clmul_arbiter.sv
// Shares one multi-cycle carry-less multiplier between NREQ requesters:
// round-robin grant, start pulse, watchdog abort and routed response.
module clmul_arbiter
  import clmul_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_mul,
  input  logic [XLEN*NREQ-1:0] req_rs1,
  input  logic [XLEN*NREQ-1:0] req_rs2,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [RLEN-1:0]      resp_rd,
  output logic                 resp_err,
  output logic                 clmul_start,
  output logic                 clmul_mul,
  output logic [XLEN-1:0]      clmul_rs1,
  output logic [XLEN-1:0]      clmul_rs2,
  input  logic [RLEN-1:0]      clmul_rd,
  input  logic                 clmul_busy,
  input  logic                 clmul_done,
  output logic                 err_sticky
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic              mul_q, mul_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [RLEN-1:0]   buf_q, buf_d;
  logic              err_q, err_d;
  logic              sticky_q, sticky_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [CNTW-1:0]   cnt_inc;

  logic [NREQ-1:0]   pick_gnt;
  logic [IDXW-1:0]   pick_idx;
  logic              pick_any;

  clmul_rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign clmul_mul  = mul_q;
  assign clmul_rs1  = rs1_q;
  assign clmul_rs2  = rs2_q;
  assign resp_rd    = buf_q;
  assign resp_err   = err_q;
  assign err_sticky = sticky_q;
  assign cnt_inc    = cnt_q + CNTW'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    mul_d       = mul_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    buf_d       = buf_q;
    err_d       = err_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    req_ready   = '0;
    resp_valid  = '0;
    clmul_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any && !clmul_busy) begin
          req_ready = pick_gnt;
          owner_d   = pick_idx;
          mul_d     = req_mul[pick_idx];
          rs1_d     = req_rs1[XLEN*pick_idx +: XLEN];
          rs2_d     = req_rs2[XLEN*pick_idx +: XLEN];
          ptr_d     = (pick_idx == IDXW'(NREQ - 1)) ? '0 : pick_idx + IDXW'(1);
          state_d   = START;
        end
      end
      START: begin
        clmul_start = 1'b1;
        cnt_d       = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        // The count includes the current cycle, so the abort lands on the
        // TIMEOUT-th WAIT cycle; a done in that same cycle still wins.
        cnt_d = cnt_inc;
        if (clmul_done) begin
          buf_d   = clmul_rd;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_inc == CNTW'(TIMEOUT)) begin
          buf_d    = '0;
          err_d    = 1'b1;
          sticky_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        resp_valid[owner_q] = 1'b1;
        if (resp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      mul_q    <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      buf_q    <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      mul_q    <= mul_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      buf_q    <= buf_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
